// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Request/acknowledge bus between the instruction-fetch stage and a
//   variable-latency instruction memory.
//
//   imem_req    fetch side -> memory   request valid
//   imem_addr   fetch side -> memory   word-aligned fetch address
//   imem_ack    memory -> fetch side   read data valid this cycle
//   imem_rdata  memory -> fetch side   instruction word, valid with imem_ack
//
//   modport master : used by the fetch unit (issues requests)
//   modport slave  : used by the instruction memory (answers requests)
// -----------------------------------------------------------------------------
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Instruction-fetch stage of a 5-stage MIPS pipeline. Owns the PC, issues
//   requests to a variable-latency instruction memory, buffers a returned
//   instruction while the pipeline is stalled, and presents im/pc4 to the
//   F/D register (nop bubble when nothing is ready). Redirects from the
//   D-stage next-PC logic follow delay-slot semantics: a redirect that
//   arrives while the delay-slot instruction is still outstanding is kept
//   pending and applied once that instruction has been consumed.
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous reset, active low
//   stall           hazard-unit stall; nothing is consumed this cycle
//   redirect_valid  D stage requests a non-sequential next PC
//   redirect_pc     redirect target (low two bits ignored)
//   imem            instruction-memory bus (master side)
//   im              instruction to F/D register, 0 when no instruction
//   pc4             PC+4 of the instruction on im, 0 when bubble
//   f_valid         im/pc4 carry a real instruction
//   pc_F            current fetch PC (trace)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    fetch_unit_if.master      imem,
    output logic [31:0]       im,
    output logic [31:0]       pc4,
    output logic              f_valid,
    output logic [31:0]       pc_F
);

    typedef enum logic [0:0] {
        FETCH = 1'b0,   // request outstanding at pc_reg
        HOLD  = 1'b1    // instruction parked in buf_*_reg during a stall
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic [31:0] buf_ir_reg;
    logic [31:0] buf_pc4_reg;
    logic        pend_valid_reg;
    logic [31:0] pend_pc_reg;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_aligned;
    logic        in_fetch;
    logic        in_hold;
    logic        ack_fetch;
    logic        valid_int;
    logic        consume;
    logic [31:0] npc;

    assign pc_plus4         = pc_reg + 32'd4;   // wraps modulo 2^32
    assign redirect_aligned = redirect_pc & 32'hFFFF_FFFC;

    // The state register already reads FETCH while reset is held, so the
    // reset level is folded in here to keep the bus and the F/D outputs
    // quiet for the whole reset window, not just after the next edge.
    always_comb begin
        in_fetch  = reset && (state_reg == FETCH);
        in_hold   = reset && (state_reg == HOLD);
        ack_fetch = in_fetch && imem.imem_ack;
        valid_int = ack_fetch || in_hold;
        consume   = valid_int && !stall;

        if (redirect_valid) begin
            npc = redirect_aligned;
        end else if (pend_valid_reg) begin
            npc = pend_pc_reg;
        end else begin
            npc = pc_plus4;
        end
    end

    // F/D-facing outputs: same-cycle pass-through of the memory word in
    // FETCH, replay of the parked word in HOLD, bubble otherwise.
    always_comb begin
        im  = 32'h0;
        pc4 = 32'h0;
        if (in_hold) begin
            im  = buf_ir_reg;
            pc4 = buf_pc4_reg;
        end else if (ack_fetch) begin
            im  = imem.imem_rdata;
            pc4 = pc_plus4;
        end
    end

    assign f_valid        = valid_int;
    assign pc_F           = pc_reg;
    assign imem.imem_req  = in_fetch;
    assign imem.imem_addr = pc_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= FETCH;
            pc_reg         <= PC_RESET;
            buf_ir_reg     <= 32'h0;
            buf_pc4_reg    <= 32'h0;
            pend_valid_reg <= 1'b0;
            pend_pc_reg    <= 32'h0;
        end else begin
            // PC only ever moves on a consume; any pending redirect is
            // used up (or superseded by a fresh one) at that moment.
            if (consume) begin
                pc_reg         <= npc;
                pend_valid_reg <= 1'b0;
            end else if (redirect_valid) begin
                // Delay slot not yet delivered: remember the target. A
                // later redirect before the consume simply overwrites it.
                pend_valid_reg <= 1'b1;
                pend_pc_reg    <= redirect_aligned;
            end

            case (state_reg)
                FETCH: begin
                    if (ack_fetch && stall) begin
                        buf_ir_reg  <= imem.imem_rdata;
                        buf_pc4_reg <= pc_plus4;
                        state_reg   <= HOLD;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state_reg <= FETCH;
                    end
                end
                default: state_reg <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] PC_RESET = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] im;
    logic [31:0] pc4;
    logic        f_valid;
    logic [31:0] pc_F;

    fetch_unit_if imem_bus ();

    fetch_unit #(.PC_RESET(PC_RESET)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem_bus),
        .im             (im),
        .pc4            (pc4),
        .f_valid        (f_valid),
        .pc_F           (pc_F)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;
    logic [31:0] scramble = 32'h0;

    // Reference model: the fetch PC, an optional instruction "in hand"
    // (returned but not yet taken by the pipeline) and an optional
    // remembered redirect target.
    logic [31:0] m_pc;
    logic        m_pend_v;
    logic [31:0] m_pend_pc;
    logic        m_held;
    logic [31:0] m_held_ir;
    logic [31:0] m_held_pc4;

    // Expectations for the current cycle and the inputs that produced them.
    logic        e_req, e_valid;
    logic [31:0] e_im, e_pc4;
    logic        c_stall, c_rv, c_ack;
    logic [31:0] c_rpc;
    logic [129:0] exp_vec, obs_vec;
    logic [129:0] reset_vec;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ scramble;
    endfunction

    task automatic model_reset();
        m_pc       = PC_RESET;
        m_pend_v   = 1'b0;
        m_pend_pc  = 32'h0;
        m_held     = 1'b0;
        m_held_ir  = 32'h0;
        m_held_pc4 = 32'h0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        imem_bus.imem_ack = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    // Drive one cycle of inputs and compute what the outputs must be.
    task automatic drive(input logic s, input logic rv, input logic [31:0] rpc, input logic ack);
        @(negedge clk);
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        imem_bus.imem_ack   = ack;
        imem_bus.imem_rdata = ack ? mem_word(imem_bus.imem_addr) : $urandom;
        c_stall = s; c_rv = rv; c_rpc = rpc; c_ack = ack;
        #1;
        e_req   = !m_held;
        e_valid = m_held || ack;
        if (m_held) begin
            e_im  = m_held_ir;
            e_pc4 = m_held_pc4;
        end else if (ack) begin
            e_im  = mem_word(m_pc);
            e_pc4 = m_pc + 32'd4;
        end else begin
            e_im  = 32'h0;
            e_pc4 = 32'h0;
        end
        exp_vec = {e_req, e_valid, e_im, e_pc4, m_pc, e_req ? m_pc : 32'h0};
        obs_vec = {imem_bus.imem_req, f_valid, im, pc4, pc_F,
                   imem_bus.imem_req ? imem_bus.imem_addr : 32'h0};
    endtask

    // Advance the model to the state it must hold after the coming edge.
    task automatic commit();
        if (e_valid && !c_stall) begin
            $display("consume im=%h pc4=%h", e_im, e_pc4);
            if (c_rv)          m_pc = c_rpc & 32'hFFFF_FFFC;
            else if (m_pend_v) m_pc = m_pend_pc;
            else               m_pc = m_pc + 32'd4;
            m_pend_v = 1'b0;
            m_held   = 1'b0;
        end else begin
            if (c_rv) begin
                m_pend_v  = 1'b1;
                m_pend_pc = c_rpc & 32'hFFFF_FFFC;
            end
            if (!m_held && c_ack && c_stall) begin
                m_held     = 1'b1;
                m_held_ir  = e_im;
                m_held_pc4 = e_pc4;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #1;
        obs_vec = {imem_bus.imem_req, f_valid, im, pc4, pc_F, 32'h0};
        n_checks++;
        if (obs_vec !== reset_vec) begin
            n_fails++;
            $display("FAIL reset_outputs: got %h required %h", obs_vec, reset_vec);
        end
        reset = 1'b1;
        imem_bus.imem_ack = 1'b0;
        model_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== PC_RESET) begin
            n_fails++;
            $display("FAIL first_request: req=%b addr=%h required req=1 addr=%h",
                     imem_bus.imem_req, imem_bus.imem_addr, PC_RESET);
        end
        commit();
    endtask

    task automatic test_sequential();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            n_checks++;
            if (obs_vec !== exp_vec || pc4 !== 32'h3004 + 32'd4 * i) begin
                n_fails++;
                $display("FAIL sequential[%0d]: got %h required %h", i, obs_vec, exp_vec);
            end
            commit();
        end
    endtask

    task automatic test_stall_hold();
        apply_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        commit();
        drive(1'b1, 1'b0, 32'h0, 1'b1);
        commit();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h0, 1'($urandom_range(0, 1)));
            n_checks++;
            if (obs_vec !== exp_vec || im !== 32'h3004 || pc4 !== 32'h3008 || imem_bus.imem_req !== 1'b0) begin
                n_fails++;
                $display("FAIL stall_hold[%0d]: got %h required %h", i, obs_vec, exp_vec);
            end
            commit();
        end
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        commit();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (obs_vec !== exp_vec || imem_bus.imem_addr !== 32'h3008) begin
            n_fails++;
            $display("FAIL hold_release: got %h required %h", obs_vec, exp_vec);
        end
        commit();
    endtask

    task automatic test_latency();
        apply_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b1); commit();
        drive(1'b0, 1'b0, 32'h0, 1'b1); commit();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 32'h0, (i == 2));
            n_checks++;
            if (obs_vec !== exp_vec || pc_F !== 32'h3008) begin
                n_fails++;
                $display("FAIL latency[%0d]: got %h required %h", i, obs_vec, exp_vec);
            end
            commit();
        end
    endtask

    task automatic test_redirect();
        apply_reset();
        drive(1'b0, 1'b1, 32'h0000_3103, 1'b1);
        commit();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (obs_vec !== exp_vec || imem_bus.imem_addr !== 32'h3100) begin
            n_fails++;
            $display("FAIL redirect_consume: got %h required %h", obs_vec, exp_vec);
        end
        commit();
    endtask

    task automatic test_delay_slot();
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b1);
            commit();
        end
        drive(1'b0, 1'b1, 32'h0000_4000, 1'b0); commit();
        drive(1'b0, 1'b0, 32'h0, 1'b0);          commit();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        n_checks++;
        if (obs_vec !== exp_vec || pc4 !== 32'h3014) begin
            n_fails++;
            $display("FAIL delay_slot_deliver: got %h required %h", obs_vec, exp_vec);
        end
        commit();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (obs_vec !== exp_vec || imem_bus.imem_addr !== 32'h4000) begin
            n_fails++;
            $display("FAIL delay_slot_target: got %h required %h", obs_vec, exp_vec);
        end
        commit();
    endtask

    task automatic test_ack_stall_redirect();
        apply_reset();
        drive(1'b1, 1'b1, 32'h0000_5001, 1'b1); commit();
        drive(1'b1, 1'b0, 32'h0, 1'b1);          commit();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (obs_vec !== exp_vec || im !== 32'h3000) begin
            n_fails++;
            $display("FAIL combo_release: got %h required %h", obs_vec, exp_vec);
        end
        commit();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (obs_vec !== exp_vec || imem_bus.imem_addr !== 32'h5000) begin
            n_fails++;
            $display("FAIL combo_target: got %h required %h", obs_vec, exp_vec);
        end
        commit();
    endtask

    task automatic test_wrap();
        apply_reset();
        drive(1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1); commit();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        n_checks++;
        if (obs_vec !== exp_vec || pc4 !== 32'h0 || f_valid !== 1'b1) begin
            n_fails++;
            $display("FAIL wrap_pc4: got %h required %h", obs_vec, exp_vec);
        end
        commit();
        drive(1'b0, 1'b0, 32'h0, 1'b0);
        n_checks++;
        if (obs_vec !== exp_vec || imem_bus.imem_addr !== 32'h0) begin
            n_fails++;
            $display("FAIL wrap_addr: got %h required %h", obs_vec, exp_vec);
        end
        commit();
    endtask

    task automatic test_reset_mid_hold();
        apply_reset();
        drive(1'b1, 1'b0, 32'h0, 1'b1); commit();
        drive(1'b1, 1'b0, 32'h0, 1'b0); commit();
        #2;
        reset = 1'b0;
        #1;
        obs_vec = {imem_bus.imem_req, f_valid, im, pc4, pc_F, 32'h0};
        n_checks++;
        if (obs_vec !== reset_vec) begin
            n_fails++;
            $display("FAIL async_reset: got %h required %h", obs_vec, reset_vec);
        end
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        n_checks++;
        if (obs_vec !== exp_vec || imem_bus.imem_addr !== PC_RESET) begin
            n_fails++;
            $display("FAIL restart_after_reset: got %h required %h", obs_vec, exp_vec);
        end
        commit();
    endtask

    task automatic test_random();
        apply_reset();
        scramble = $urandom;
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 15),
                  $urandom, ($urandom_range(0, 99) < 60));
            n_checks++;
            if (obs_vec !== exp_vec) begin
                n_fails++;
                $display("FAIL random[%0d]: got %h required %h", i, obs_vec, exp_vec);
            end
            commit();
        end
        scramble = 32'h0;
    endtask

    initial begin
        reset_vec = {1'b0, 1'b0, 32'h0, 32'h0, PC_RESET, 32'h0};
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        model_reset();
        test_reset();
        test_sequential();
        test_stall_hold();
        test_latency();
        test_redirect();
        test_delay_slot();
        test_ack_stall_redirect();
        test_wrap();
        test_reset_mid_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
